// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic array slice: operand/accumulator widths
// used by both the feeder and the PE grid, and the feeder sequencer states.
// No ports (package).
// ---------------------------------------------------------------------------
package systolic_pkg;

  localparam int COMPUTE_DATA_WIDTH     = 4;
  localparam int ACCUMULATOR_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LATCH,
    STREAM,
    DRAIN
  } feeder_state_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// ---------------------------------------------------------------------------
// systolic_feeder_if
// Bundles the upstream valid/ready vector stream and the grid-facing lanes of
// the systolic feeder.
//   s_valid/s_ready/s_data/s_last : upstream vector handshake
//   row_in                        : per-row data to the column-0 PEs
//   load_en                       : broadcast weight capture strobe
//   compute                       : per-row compute enable
// Modports: master = upstream buffer / grid side, slave = feeder side.
// ---------------------------------------------------------------------------
interface systolic_feeder_if
  import systolic_pkg::*;
#(
  parameter int ROWS  = 4,
  parameter int WIDTH = systolic_pkg::COMPUTE_DATA_WIDTH
);

  logic                  s_valid;
  logic                  s_ready;
  logic [ROWS*WIDTH-1:0] s_data;
  logic                  s_last;
  logic [ROWS*WIDTH-1:0] row_in;
  logic                  load_en;
  logic [ROWS-1:0]       compute;

  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, row_in, load_en, compute
  );

  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, row_in, load_en, compute
  );

endinterface

// File: rtl/systolic_feeder_skew_line.sv
// ---------------------------------------------------------------------------
// skew_line
// Fixed-depth register chain that delays one row's {compute, data} word so the
// rows of the grid see their operands on a diagonal wavefront.
//   clk, rst_n : clock, asynchronous active-low reset
//   d_i        : word entering the line
//   q_o        : word leaving the line DEPTH cycles later (DEPTH = 0: wire)
// ---------------------------------------------------------------------------
module skew_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Row 0 needs no delay, so the clock and reset are intentionally unused.
      logic unusedClkRst;
      assign unusedClkRst = clk ^ rst_n;
      assign q_o = d_i;
    end else begin : g_chain
      logic [WIDTH-1:0] pipe_q [DEPTH];

      // Shift the word one stage per cycle; reset empties the whole line.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            pipe_q[i] <= '0;
          end
        end else begin
          pipe_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign q_o = pipe_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
// Transmit-side sequencer for a ROWS x COLS weight-stationary PE grid. Loads
// weights unskewed and pulses load_en, or streams activations through a
// per-row diagonal skew, then flushes the grid and pulses done.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start_load     : one-cycle command in IDLE, begin a weight load (wins ties)
//   start_compute  : one-cycle command in IDLE, begin an activation stream
//   bus (slave)    : s_valid/s_ready/s_data/s_last in, row_in/load_en/compute out
//   busy           : high whenever the sequencer is not IDLE
//   done           : one-cycle pulse when an operation completes
// Optional build macro SYSTOLIC_FEEDER_STATS_EN adds:
//   stat_vectors   : saturating count of STREAM handshakes
//   stat_stalls    : saturating count of STREAM cycles with s_valid low
// ---------------------------------------------------------------------------
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int ROWS               = 4,
  parameter int COLS               = 4,
  parameter int COMPUTE_DATA_WIDTH = systolic_pkg::COMPUTE_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_load,
  input  logic             start_compute,
  systolic_feeder_if.slave bus,
  output logic             busy,
  output logic             done
`ifdef SYSTOLIC_FEEDER_STATS_EN
  ,
  output logic [31:0]      stat_vectors,
  output logic [31:0]      stat_stalls
`endif
);

  localparam int W   = COMPUTE_DATA_WIDTH;
  localparam int WCW = $clog2(COLS + 1);
  localparam int FCW = $clog2(ROWS + COLS);
  localparam logic [WCW-1:0] LAST_WEIGHT = WCW'(COLS - 1);
  localparam logic [FCW-1:0] FLUSH_LEN   = FCW'(ROWS - 1 + COLS - 1);

  feeder_state_t    state_q, state_d;
  logic [WCW-1:0]   weightCnt_q, weightCnt_d;
  logic [FCW-1:0]   flushCnt_q, flushCnt_d;
  logic [ROWS*W-1:0] stageData_q, stageData_d;
  logic             stageFlag_q, stageFlag_d;
  logic             done_q, done_d;

  logic             sReady;
  logic             loadEn;
  logic             busyInt;
  logic             weightPhase;
  logic             lastWeight;
  logic [ROWS*W-1:0] skewData;
  logic [ROWS-1:0]  skewFlag;

  assign lastWeight = (weightCnt_q == LAST_WEIGHT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Commands only matter in IDLE; a weight load moves on
  // after the COLS-th accepted vector, a stream after the vector flagged last.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d = LOAD_W;
        end else if (start_compute) begin
          state_d = STREAM;
        end
      end
      LOAD_W: begin
        if (bus.s_valid && lastWeight) begin
          state_d = LATCH;
        end
      end
      LATCH:  state_d = DRAIN;
      STREAM: begin
        if (bus.s_valid && bus.s_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (flushCnt_q == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the current state. During the weight phase row_in
  // bypasses the skew lines so every row sees its weight at the same time.
  always_comb begin
    sReady      = (state_q == LOAD_W) || (state_q == STREAM);
    loadEn      = (state_q == LATCH);
    busyInt     = (state_q != IDLE);
    weightPhase = (state_q == LOAD_W) || (state_q == LATCH);
  end

  // Counters and the shared input stage. Weights hold across stalls; in the
  // stream every cycle enters the skew, a bubble being data 0 / compute 0.
  // done is registered so it rises together with the return to IDLE.
  always_comb begin
    weightCnt_d = weightCnt_q;
    flushCnt_d  = flushCnt_q;
    stageData_d = '0;
    stageFlag_d = 1'b0;
    done_d      = (state_q == DRAIN) && (flushCnt_q == '0);
    case (state_q)
      IDLE: begin
        weightCnt_d = '0;
        flushCnt_d  = '0;
      end
      LOAD_W: begin
        stageData_d = stageData_q;
        if (bus.s_valid) begin
          stageData_d = bus.s_data;
          weightCnt_d = lastWeight ? '0 : weightCnt_q + WCW'(1);
        end
      end
      LATCH: begin
        flushCnt_d = '0;
      end
      STREAM: begin
        if (bus.s_valid) begin
          stageData_d = bus.s_data;
          stageFlag_d = 1'b1;
          if (bus.s_last) begin
            flushCnt_d = FLUSH_LEN;
          end
        end
      end
      DRAIN: begin
        if (flushCnt_q != '0) begin
          flushCnt_d = flushCnt_q - FCW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weightCnt_q <= '0;
      flushCnt_q  <= '0;
      stageData_q <= '0;
      stageFlag_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      weightCnt_q <= weightCnt_d;
      flushCnt_q  <= flushCnt_d;
      stageData_q <= stageData_d;
      stageFlag_q <= stageFlag_d;
      done_q      <= done_d;
    end
  end

  // One skew line per row, depth equal to the row index. Data is gated by the
  // compute flag so held weights never leak into the skewed lanes.
  generate
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [W:0] laneIn;
      logic [W:0] laneOut;

      assign laneIn = {stageFlag_q, stageFlag_q ? stageData_q[r*W +: W] : {W{1'b0}}};

      skew_line #(
        .DEPTH (r),
        .WIDTH (W + 1)
      ) u_skew (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (laneIn),
        .q_o   (laneOut)
      );

      assign skewData[r*W +: W] = laneOut[W-1:0];
      assign skewFlag[r]        = laneOut[W];
    end
  endgenerate

  assign bus.s_ready = sReady;
  assign bus.load_en = loadEn;
  assign bus.row_in  = weightPhase ? stageData_q : skewData;
  assign bus.compute = skewFlag;
  assign busy        = busyInt;
  assign done        = done_q;

`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [31:0] statVectors_q;
  logic [31:0] statStalls_q;

  // Stream statistics: cleared by a start_compute seen in IDLE, counted only
  // while streaming, and pinned at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statVectors_q <= '0;
      statStalls_q  <= '0;
    end else if ((state_q == IDLE) && start_compute) begin
      statVectors_q <= '0;
      statStalls_q  <= '0;
    end else if (state_q == STREAM) begin
      if (bus.s_valid) begin
        if (statVectors_q != '1) begin
          statVectors_q <= statVectors_q + 32'd1;
        end
      end else if (statStalls_q != '1) begin
        statStalls_q <= statStalls_q + 32'd1;
      end
    end
  end

  assign stat_vectors = statVectors_q;
  assign stat_stalls  = statStalls_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder
// Directed and randomized checks of systolic_feeder against a reference model
// that describes the feeder by its timing rules: row r shows whatever was
// accepted r+1 cycles earlier, weights appear unskewed, done lands a fixed
// number of cycles after the final vector. Builds with or without
// SYSTOLIC_FEEDER_STATS_EN.
// ---------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int W     = 4;
  localparam int VW    = ROWS * W;
  localparam int FLUSH = (ROWS - 1) + (COLS - 1);
  localparam int MAXC  = 4096;
  localparam int BIG   = 1 << 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_load = 1'b0;
  logic start_compute = 1'b0;
  logic busy;
  logic done;
`ifdef SYSTOLIC_FEEDER_STATS_EN
  logic [31:0] stat_vectors;
  logic [31:0] stat_stalls;
`endif

  systolic_feeder_if #(.ROWS(ROWS), .WIDTH(W)) bus ();

  systolic_feeder #(
    .ROWS               (ROWS),
    .COLS               (COLS),
    .COMPUTE_DATA_WIDTH (W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_load    (start_load),
    .start_compute (start_compute),
    .bus           (bus),
    .busy          (busy),
    .done          (done)
`ifdef SYSTOLIC_FEEDER_STATS_EN
    ,
    .stat_vectors  (stat_vectors),
    .stat_stalls   (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state. cyc counts clock edges; inj* record what entered
  // the grid wavefront at each edge (zero for anything but a stream handshake).
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          injFlag [MAXC];
  logic [VW-1:0] injData [MAXC];
  bit          loading = 0;
  bit          streaming = 0;
  bit          doneValid = 0;
  int          doneEdge = 0;
  int          wStart = 1;
  int          weightEnd = -1;
  int          weightsSent = 0;
  logic [VW-1:0] lastWeight = '0;
  int          statVec = 0;
  int          statStall = 0;

  function automatic logic [VW-1:0] expRow();
    logic [VW-1:0] v;
    v = '0;
    if (cyc >= wStart && cyc <= weightEnd) begin
      v = lastWeight;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        int k;
        k = cyc - r;
        if (k >= 0 && injFlag[k]) v[r*W +: W] = injData[k][r*W +: W];
      end
    end
    return v;
  endfunction

  function automatic logic [ROWS-1:0] expCompute();
    logic [ROWS-1:0] c;
    c = '0;
    for (int r = 0; r < ROWS; r++) begin
      int k;
      k = cyc - r;
      if (k >= 0) c[r] = injFlag[k];
    end
    return c;
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("row_in",  64'(bus.row_in),  64'(expRow()));
    cmp("compute", 64'(bus.compute), 64'(expCompute()));
    cmp("load_en", 64'(bus.load_en), 64'(cyc == weightEnd));
    cmp("s_ready", 64'(bus.s_ready), 64'(loading || streaming));
    cmp("busy",    64'(busy),        64'(cyc < doneEdge));
    cmp("done",    64'(done),        64'(doneValid && (cyc == doneEdge)));
`ifdef SYSTOLIC_FEEDER_STATS_EN
    cmp("stat_vectors", 64'(stat_vectors), 64'(statVec));
    cmp("stat_stalls",  64'(stat_stalls),  64'(statStall));
`endif
  endtask

  // Drive one cycle of inputs, advance the model across the coming edge,
  // then clock and compare just after the edge.
  task automatic applyStimulus(input bit sl, input bit sc, input bit v,
                               input logic [VW-1:0] d, input bit l);
    int e;
    e = cyc + 1;
    if (e >= MAXC) begin
      $display("[TB] FAIL cycle_budget observed=%0d required<%0d", e, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    start_load    = sl;
    start_compute = sc;
    bus.s_valid   = v;
    bus.s_data    = d;
    bus.s_last    = l;
    injFlag[e] = 1'b0;
    injData[e] = '0;
    if (rst_n) begin
      if (cyc >= doneEdge) begin
        if (sc) begin
          statVec   = 0;
          statStall = 0;
        end
        if (sl) begin
          loading     = 1;
          wStart      = e;
          weightEnd   = BIG;
          lastWeight  = '0;
          weightsSent = 0;
          doneEdge    = BIG;
        end else if (sc) begin
          streaming = 1;
          doneEdge  = BIG;
        end
      end else if (loading) begin
        if (v) begin
          lastWeight = d;
          weightsSent++;
          if (weightsSent == COLS) begin
            loading   = 0;
            weightEnd = e;
            doneEdge  = e + 2;
            doneValid = 1;
          end
        end
      end else if (streaming) begin
        if (v) begin
          injFlag[e] = 1'b1;
          injData[e] = d;
          statVec++;
          if (l) begin
            streaming = 0;
            doneEdge  = e + FLUSH + 1;
            doneValid = 1;
          end
        end else begin
          statStall++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc = e;
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, '0, 0);
  endtask

  task automatic modelReset();
    loading   = 0;
    streaming = 0;
    doneValid = 0;
    doneEdge  = cyc;
    wStart    = 1;
    weightEnd = -1;
    statVec   = 0;
    statStall = 0;
    for (int k = 0; k < MAXC; k++) begin
      injFlag[k] = 1'b0;
      injData[k] = '0;
    end
  endtask

  task automatic randomStream(input int n);
    int sent;
    sent = 0;
    applyStimulus(0, 1, 0, '0, 0);
    while (sent < n) begin
      if ($urandom_range(0, 2) == 0) begin
        applyStimulus(0, 0, 0, VW'($urandom), 1'($urandom_range(0, 1)));
      end else begin
        sent++;
        applyStimulus(0, 0, 1, VW'($urandom), sent == n);
      end
    end
    idleCycles(FLUSH + 3);
  endtask

  task automatic randomLoad();
    int sent;
    sent = 0;
    applyStimulus(1, 0, 0, '0, 0);
    while (sent < COLS) begin
      if ($urandom_range(0, 2) == 0) begin
        applyStimulus(0, 0, 0, VW'($urandom), 0);
      end else begin
        sent++;
        applyStimulus(0, 0, 1, VW'($urandom), 1'($urandom_range(0, 1)));
      end
    end
    idleCycles(4);
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    modelReset();

    $display("[TB] reset state");
    applyStimulus(0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, '0, 0);
    #2 rst_n = 1'b1;
    idleCycles(2);

    $display("[TB] weight load, s_last ignored");
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(0, 0, 1, 16'h4321, 0);
    applyStimulus(0, 0, 1, 16'h8765, 1);
    applyStimulus(0, 0, 1, 16'hCBA9, 0);
    applyStimulus(0, 0, 1, 16'h0FED, 0);
    idleCycles(4);

    $display("[TB] single-vector stream skew");
    applyStimulus(0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, 16'h4321, 1);
    idleCycles(FLUSH + 3);

    $display("[TB] stalls between vectors");
    applyStimulus(0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    applyStimulus(0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, '0, 0);
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    applyStimulus(0, 0, 1, VW'($urandom), 1);
    idleCycles(FLUSH + 3);

    $display("[TB] command priority and commands while busy");
    applyStimulus(1, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    applyStimulus(0, 1, 1, VW'($urandom), 0);
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    idleCycles(4);
    applyStimulus(0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    applyStimulus(1, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, VW'($urandom), 1);
    applyStimulus(1, 0, 0, '0, 0);
    idleCycles(FLUSH + 2);

    $display("[TB] stream counters: 5 vectors, 3 stalls");
    applyStimulus(0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    applyStimulus(0, 0, 0, '0, 0);
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    applyStimulus(0, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    applyStimulus(0, 0, 1, VW'($urandom), 1);
    idleCycles(FLUSH + 3);
    applyStimulus(0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, VW'($urandom), 1);
    idleCycles(FLUSH + 3);

    $display("[TB] randomized streams and loads");
    for (int t = 0; t < 6; t++) begin
      randomStream($urandom_range(1, 12));
      if (t % 2 == 0) randomLoad();
    end

    $display("[TB] reset mid-stream");
    applyStimulus(0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    bus.s_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput();
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    #2 rst_n = 1'b1;
    applyStimulus(0, 0, 1, VW'($urandom), 0);
    applyStimulus(0, 1, 0, '0, 0);
    applyStimulus(0, 0, 1, VW'($urandom), 1);
    idleCycles(FLUSH + 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
